// File: rtl/chimera_pkg.sv
// Shared types and defaults for the chimera cluster clock-gate sequencer.
package chimera_pkg;

  // Per-cluster sequencer states.
  typedef enum logic [2:0] {
    RUN     = 3'd0,
    ISOLATE = 3'd1,
    GATED   = 3'd2,
    WAKE    = 3'd3,
    FAULT   = 3'd4
  } clu_clk_state_e;

  // Default drain budget (cycles in ISOLATE) and wake settle window.
  localparam int unsigned CluDrainTimeout = 1024;
  localparam int unsigned CluWakeCycles   = 4;

  // Counter width large enough to hold the larger of the two limits.
  function automatic int unsigned clu_cnt_width(input int unsigned drain,
                                                input int unsigned wake);
    int unsigned lim;
    lim = (drain > wake) ? drain : wake;
    return $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/chimera_clu_clk_fsm.sv
// Clock-gate sequencer for a single cluster: isolate -> drain -> gate,
// and ungate -> settle -> release, with a sticky drain-timeout fault.
// Handshake: gate_req_i is a level request; isolate_o asks the AXI isolate
// cell to drain, isolated_i is its level acknowledge; there is no
// valid/ready pairing, every transfer is a level held until observed.
module chimera_clu_clk_fsm
  import chimera_pkg::*;
#(
  parameter int unsigned DrainTimeout = CluDrainTimeout,
  parameter int unsigned WakeCycles   = CluWakeCycles,
  parameter int unsigned CntWidth     = clu_cnt_width(DrainTimeout, WakeCycles)
) (
  input  logic       soc_clk_i,
  input  logic       rst_ni,
  input  logic       gate_req_i,
  input  logic       clear_fault_i,
  input  logic       isolated_i,
  output logic       isolate_o,
  output logic       clk_en_o,
  output logic       gated_o,
  output logic       busy_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  localparam logic [CntWidth-1:0] CntMax   = '1;
  localparam logic [CntWidth-1:0] DrainEnd = CntWidth'(DrainTimeout - 1);
  localparam logic [CntWidth-1:0] WakeEnd  = CntWidth'(WakeCycles - 1);

  clu_clk_state_e      state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                fault_q, fault_d;

  // State, counter and sticky fault registers; reset lands in RUN clocked.
  always_ff @(posedge soc_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Next-state, counter and fault update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    if (clear_fault_i) fault_d = 1'b0;

    unique case (state_q)
      RUN: begin
        if (gate_req_i) state_d = ISOLATE;
      end
      ISOLATE: begin
        // Cancel beats ack, ack beats timeout (a tie gates without fault).
        if (!gate_req_i) begin
          state_d = RUN;
        end else if (isolated_i) begin
          state_d = GATED;
        end else if (cnt_q == DrainEnd) begin
          state_d = FAULT;
          fault_d = 1'b1;  // set wins over a same-cycle clear
        end
      end
      GATED: begin
        if (!gate_req_i) state_d = WAKE;
      end
      WAKE: begin
        if (cnt_q == WakeEnd) state_d = RUN;
      end
      FAULT: begin
        if (!gate_req_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    // Counter restarts on every state entry and saturates otherwise.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == ISOLATE || state_q == WAKE) && cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs decode registered state only.
  assign clk_en_o  = (state_q != GATED);
  assign isolate_o = (state_q == ISOLATE) || (state_q == GATED) || (state_q == WAKE);
  assign gated_o   = (state_q == GATED);
  assign busy_o    = (state_q == ISOLATE) || (state_q == WAKE);
  assign fault_o   = fault_q;
  assign state_o   = state_q;

endmodule

// File: rtl/chimera_clu_clk_ctrl.sv
// Per-cluster clock-gate sequencer array for the chimera cluster domain.
// Each cluster runs an independent chimera_clu_clk_fsm; there is no
// cross-cluster interaction. dbg_state_o exposes each FSM's state.
module chimera_clu_clk_ctrl
  import chimera_pkg::*;
#(
  parameter int unsigned NumClusters  = 5,
  parameter int unsigned DrainTimeout = CluDrainTimeout,
  parameter int unsigned WakeCycles   = CluWakeCycles
) (
  input  logic                        soc_clk_i,
  input  logic                        rst_ni,
  input  logic [NumClusters-1:0]      gate_req_i,
  input  logic [NumClusters-1:0]      clear_fault_i,
  input  logic [NumClusters-1:0]      isolated_i,
  output logic [NumClusters-1:0]      isolate_o,
  output logic [NumClusters-1:0]      clk_en_o,
  output logic [NumClusters-1:0]      gated_o,
  output logic [NumClusters-1:0]      busy_o,
  output logic [NumClusters-1:0]      fault_o,
  output logic [NumClusters-1:0][2:0] dbg_state_o
);

  localparam int unsigned CntWidth = clu_cnt_width(DrainTimeout, WakeCycles);

  for (genvar i = 0; i < NumClusters; i++) begin : g_clu
    chimera_clu_clk_fsm #(
      .DrainTimeout (DrainTimeout),
      .WakeCycles   (WakeCycles),
      .CntWidth     (CntWidth)
    ) u_fsm (
      .soc_clk_i     (soc_clk_i),
      .rst_ni        (rst_ni),
      .gate_req_i    (gate_req_i[i]),
      .clear_fault_i (clear_fault_i[i]),
      .isolated_i    (isolated_i[i]),
      .isolate_o     (isolate_o[i]),
      .clk_en_o      (clk_en_o[i]),
      .gated_o       (gated_o[i]),
      .busy_o        (busy_o[i]),
      .fault_o       (fault_o[i]),
      .state_o       (dbg_state_o[i])
    );
  end

endmodule
